// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side arbiter.
package uart_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  // Serializer timing: clocks per bit and bits per frame (start + 8 data + stop)
  localparam int CLKS_PER_BIT = 838;
  localparam int FRAME_BITS   = 10;
  localparam int FRAME_CYCLES = CLKS_PER_BIT * FRAME_BITS;

  // Watchdog default: the next power of two strictly above one full frame,
  // which leaves close to a 2x margin over the 8380-cycle frame.
  localparam int DEFAULT_TIMEOUT_CYCLES = 2 ** $clog2(FRAME_CYCLES + 1);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches the request vector starting one
// position past the last grant and wrapping from N_REQ-1 back to 0.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDW-1:0]   i_last_grant,
  output logic [IDW-1:0]   o_grant,
  output logic             o_any
);

  // One extra bit so last_grant + offset (at most 2*N_REQ-1) never overflows
  localparam int           SW     = IDW + 1;
  localparam logic [SW-1:0] NREQ_W = SW'(N_REQ);

  logic [SW-1:0] w_sum;

  // First requesting index in rotated priority order wins
  always_comb begin
    o_grant = '0;
    o_any   = 1'b0;
    w_sum   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_sum = {1'b0, i_last_grant} + SW'(k);
      if (w_sum >= NREQ_W) begin
        w_sum = w_sum - NREQ_W;
      end
      if (!o_any && i_req[w_sum[IDW-1:0]]) begin
        o_any   = 1'b1;
        o_grant = w_sum[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX serializer among N_REQ byte producers. A byte is picked
// round-robin in IDLE, launched with a one-cycle start pulse, and held until
// the serializer reports done or the watchdog expires. An optional idle gap
// follows each completed frame.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int GAP_CYCLES     = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [N_REQ-1:0]           i_req_valid,
  input  logic [N_REQ-1:0][7:0]      i_req_byte,
  output logic [N_REQ-1:0]           o_req_ready,
  output logic                       o_tx_start,
  output logic [7:0]                 o_tx_byte,
  input  logic                       i_tx_busy,
  input  logic                       i_tx_done,
  output logic [$clog2(N_REQ)-1:0]   o_grant_id,
  output logic                       o_busy,
  output logic                       o_timeout_err
);

  localparam int IDW = $clog2(N_REQ);
  localparam int WDW = $clog2(TIMEOUT_CYCLES);
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [IDW-1:0] LAST_INIT = IDW'(N_REQ - 1);
  localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0]  GAP_LAST  = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;

  logic [IDW-1:0]   r_last_grant;
  logic [IDW-1:0]   r_grant_id;
  logic [7:0]       r_tx_byte;
  logic             r_tx_start;
  logic [N_REQ-1:0] r_req_ready;
  logic             r_timeout_err;
  logic [WDW-1:0]   r_wd_cnt;
  logic [GW-1:0]    r_gap_cnt;

  logic [IDW-1:0]   w_grant;
  logic             w_any;
  logic             w_launch;
  logic             w_timeout;
  logic [N_REQ-1:0] w_ready_oh;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr (
    .i_req        (i_req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_any        (w_any)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; done takes priority over a watchdog hit in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any && !i_tx_busy) begin
          w_state_nxt = ST_WAIT;
          w_launch    = 1'b1;
        end
      end
      ST_WAIT: begin
        if (i_tx_done) begin
          w_state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end else if (r_wd_cnt == WD_LAST) begin
          w_state_nxt = ST_IDLE;
          w_timeout   = 1'b1;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // One-hot decode of the winning requester for the accept pulse
  always_comb begin
    w_ready_oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_ready_oh[i] = (w_grant == IDW'(i));
    end
  end

  // Watchdog: zero on WAIT entry, counts every cycle spent in WAIT
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wd_cnt <= '0;
    end else if (r_state == ST_WAIT) begin
      r_wd_cnt <= r_wd_cnt + WDW'(1);
    end else begin
      r_wd_cnt <= '0;
    end
  end

  // Inter-frame gap counter: counts cycles spent in GAP
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gap_cnt <= '0;
    end else if (r_state == ST_GAP) begin
      r_gap_cnt <= r_gap_cnt + GW'(1);
    end else begin
      r_gap_cnt <= '0;
    end
  end

  // Grant capture and single-cycle output pulses; the byte is latched at
  // grant time so a requester dropping valid early still gets its byte sent
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_start    <= 1'b0;
      r_req_ready   <= '0;
      r_timeout_err <= 1'b0;
      r_tx_byte     <= '0;
      r_grant_id    <= '0;
      r_last_grant  <= LAST_INIT;
    end else begin
      r_tx_start    <= w_launch;
      r_req_ready   <= w_launch ? w_ready_oh : '0;
      r_timeout_err <= w_timeout;
      if (w_launch) begin
        r_tx_byte    <= i_req_byte[w_grant];
        r_grant_id   <= w_grant;
        r_last_grant <= w_grant;
      end
    end
  end

  assign o_req_ready   = r_req_ready;
  assign o_tx_start    = r_tx_start;
  assign o_tx_byte     = r_tx_byte;
  assign o_grant_id    = r_grant_id;
  assign o_timeout_err = r_timeout_err;
  assign o_busy        = (r_state != ST_IDLE);

endmodule
